// File: rtl/afifo_stream_reader.sv
// -----------------------------------------------------------------------------
// afifo_stream_reader
//
// Read-side consumer for the dual-clock FIFO. Lives entirely in the FIFO read
// clock domain. It pops words from the FIFO read port and re-presents them as
// a valid/ready stream. A 2-entry skid buffer sits between the two:
//   - slot A always drives m_data;
//   - slot B catches the word fetched in the same cycle the consumer stalls.
// Because of this, the stream can move one word per cycle, and m_valid, m_data
// and m_last come straight from registers with no path from m_ready.
//
// Every BURST_LEN-th accepted beat is flagged with m_last.
//
// Parameters
//   WIDTH      data word width; must match the FIFO WIDTH
//   BURST_LEN  beats per burst (>= 1)
//   CNT_WIDTH  statistics counter width (only used with AFIFO_RD_STATS_EN)
//
// Ports
//   read_clk        in   1          sole clock (FIFO read clock)
//   read_reset      in   1          synchronous, active-high reset
//   drain_en        in   1          1 = fetch words from the FIFO
//   fifo_empty      in   1          FIFO empty flag
//   fifo_read_data  in   WIDTH      FIFO head word (valid while !fifo_empty)
//   fifo_read_en    out  1          FIFO pop strobe (combinational)
//   m_valid         out  1          output word valid
//   m_ready         in   1          downstream accepts the word
//   m_data          out  WIDTH      output word
//   m_last          out  1          last beat of the current burst
//   occupancy       out  2          words held in the skid buffer (0..2)
//   word_count      out  CNT_WIDTH  saturating count of accepted words
//                                   (AFIFO_RD_STATS_EN only)
//   stall_count     out  CNT_WIDTH  saturating count of m_valid & !m_ready
//                                   cycles (AFIFO_RD_STATS_EN only)
//
// Build option
//   AFIFO_RD_STATS_EN  when defined, adds the word_count/stall_count outputs.
//                      When undefined, those ports and counters do not exist
//                      and all other behaviour is unchanged.
// -----------------------------------------------------------------------------
module afifo_stream_reader #(
    parameter int WIDTH     = 32,
    parameter int BURST_LEN = 8,
    parameter int CNT_WIDTH = 16
) (
    input  logic             read_clk,
    input  logic             read_reset,
    input  logic             drain_en,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_read_data,
    output logic             fifo_read_en,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic [1:0]       occupancy
`ifdef AFIFO_RD_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] word_count,
    output logic [CNT_WIDTH-1:0] stall_count
`endif
);

    // -------------------------------------------------------------------------
    // Skid buffer state. The encoding equals the number of words held, so the
    // state register doubles as the occupancy output.
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  slot_a_q, slot_a_d;   // head word, drives m_data
    logic [WIDTH-1:0]  slot_b_q, slot_b_d;   // skid word

    logic              fetch;
    logic              pop;
    logic              last_beat;            // burst position is at the final beat

    // -------------------------------------------------------------------------
    // Handshakes
    // -------------------------------------------------------------------------
    // read_reset is folded in so the FIFO is never popped during a reset cycle;
    // otherwise the word would be taken from the FIFO and then thrown away by
    // the reset of the skid buffer.
    assign fetch        = drain_en && !fifo_empty && (state_q != ST_TWO) && !read_reset;
    assign fifo_read_en = fetch;

    assign m_valid   = (state_q != ST_EMPTY);
    assign pop       = m_valid && m_ready;
    assign m_data    = slot_a_q;
    assign occupancy = state_q;
    assign m_last    = m_valid && last_beat;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        slot_a_d = slot_a_q;
        slot_b_d = slot_b_q;

        unique case (state_q)
            ST_EMPTY: begin
                if (fetch) begin
                    state_d  = ST_ONE;
                    slot_a_d = fifo_read_data;
                end
            end

            ST_ONE: begin
                if (fetch && pop) begin
                    // Head leaves while the next word arrives: refill A in place.
                    slot_a_d = fifo_read_data;
                end else if (fetch) begin
                    // Consumer stalled; the word already in flight goes to B.
                    state_d  = ST_TWO;
                    slot_b_d = fifo_read_data;
                end else if (pop) begin
                    state_d  = ST_EMPTY;
                end
            end

            ST_TWO: begin
                // fetch is impossible here; only draining moves the state.
                if (pop) begin
                    state_d  = ST_ONE;
                    slot_a_d = slot_b_q;
                end
            end

            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and storage registers
    // -------------------------------------------------------------------------
    always_ff @(posedge read_clk) begin
        if (read_reset) begin
            state_q  <= ST_EMPTY;
            slot_a_q <= '0;
            slot_b_q <= '0;
        end else begin
            state_q  <= state_d;
            slot_a_q <= slot_a_d;
            slot_b_q <= slot_b_d;
        end
    end

    // -------------------------------------------------------------------------
    // Burst beat counter. With BURST_LEN = 1 every beat is the last one, so no
    // counter is built at all.
    // -------------------------------------------------------------------------
    generate
        if (BURST_LEN <= 1) begin : g_single_beat
            assign last_beat = 1'b1;
        end else begin : g_beat_counter
            localparam int BEAT_W = $clog2(BURST_LEN);
            localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BURST_LEN - 1);

            logic [BEAT_W-1:0] beat_q, beat_d;

            always_comb begin
                beat_d = beat_q;
                if (pop) begin
                    beat_d = (beat_q == BEAT_MAX) ? '0 : beat_q + 1'b1;
                end
            end

            // Only accepted beats advance the position, so pausing the drain
            // or stalling the consumer keeps the burst position intact.
            always_ff @(posedge read_clk) begin
                if (read_reset) begin
                    beat_q <= '0;
                end else begin
                    beat_q <= beat_d;
                end
            end

            assign last_beat = (beat_q == BEAT_MAX);
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Optional statistics
    // -------------------------------------------------------------------------
`ifdef AFIFO_RD_STATS_EN
    logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic                 stall;

    assign stall = m_valid && !m_ready;

    // Both counters stick at all-ones instead of wrapping, so a saturated
    // value is unambiguous to software reading them.
    always_comb begin
        word_cnt_d  = word_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (pop && (word_cnt_q != '1)) begin
            word_cnt_d = word_cnt_q + 1'b1;
        end
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge read_clk) begin
        if (read_reset) begin
            word_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            word_cnt_q  <= word_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign word_count  = word_cnt_q;
    assign stall_count = stall_cnt_q;
`else
    // CNT_WIDTH only sizes the statistics counters; this empty block merely
    // keeps the parameter referenced in builds without them.
    generate
        if (CNT_WIDTH < 1) begin : g_no_stats_cnt_width
        end
    endgenerate
`endif

endmodule

// File: tb/tb_afifo_stream_reader.sv
// -----------------------------------------------------------------------------
// Directed testbench for afifo_stream_reader (BURST_LEN = 4, CNT_WIDTH = 4).
// The FIFO is a small queue owned by the stimulus: it presents its head word
// and drops it after every clock edge at which fifo_read_en was high.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_afifo_stream_reader;

    localparam int WIDTH     = 32;
    localparam int BURST_LEN = 4;
    localparam int CNT_WIDTH = 4;

    logic             read_clk = 1'b0;
    logic             read_reset;
    logic             drain_en;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_read_data;
    logic             fifo_read_en;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;
    logic [1:0]       occupancy;
`ifdef AFIFO_RD_STATS_EN
    logic [CNT_WIDTH-1:0] word_count;
    logic [CNT_WIDTH-1:0] stall_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int rd_pulses = 0;

    logic [WIDTH-1:0] fifo_mem[$];

    always #5 read_clk = ~read_clk;

    afifo_stream_reader #(
        .WIDTH    (WIDTH),
        .BURST_LEN(BURST_LEN),
        .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .read_clk      (read_clk),
        .read_reset    (read_reset),
        .drain_en      (drain_en),
        .fifo_empty    (fifo_empty),
        .fifo_read_data(fifo_read_data),
        .fifo_read_en  (fifo_read_en),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_last        (m_last),
        .occupancy     (occupancy)
`ifdef AFIFO_RD_STATS_EN
        ,
        .word_count    (word_count),
        .stall_count   (stall_count)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fifo_update();
        fifo_empty     = (fifo_mem.size() == 0);
        fifo_read_data = fifo_empty ? '0 : fifo_mem[0];
    endtask

    // One clock: sample the pop strobe before the edge, then pop the model
    // FIFO and leave the caller 1 ns after the edge to check outputs.
    task automatic tick();
        logic fre;
        #1;
        fre = fifo_read_en;
        chk("no_underflow_pop", {63'b0, fre & fifo_empty}, 64'd0);
        @(posedge read_clk);
        #1;
        if (fre) begin
            rd_pulses++;
            void'(fifo_mem.pop_front());
        end
        fifo_update();
    endtask

    initial begin
        // ---------------- 1: reset held 3 cycles with a non-empty FIFO -------
        read_reset = 1'b1;
        drain_en   = 1'b1;
        m_ready    = 1'b0;
        fifo_mem.push_back(32'hDEAD_BEEF);
        fifo_update();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("reset_rd_en", {63'b0, fifo_read_en}, 64'd0);
            tick();
            chk("reset_valid", {63'b0, m_valid}, 64'd0);
            chk("reset_data", {32'b0, m_data}, 64'd0);
            chk("reset_occ", {62'b0, occupancy}, 64'd0);
            chk("reset_last", {63'b0, m_last}, 64'd0);
        end
        fifo_mem.delete();

        // ---------------- 2: three words streamed back to back ---------------
        read_reset = 1'b0;
        m_ready    = 1'b1;
        fifo_mem.push_back(32'h11);
        fifo_mem.push_back(32'h22);
        fifo_mem.push_back(32'h33);
        fifo_update();
        #1;
        chk("t2_first_rd_en", {63'b0, fifo_read_en}, 64'd1);
        chk("t2_valid_before", {63'b0, m_valid}, 64'd0);
        tick();
        chk("t2_valid0", {63'b0, m_valid}, 64'd1);
        chk("t2_data0", {32'b0, m_data}, 64'h11);
        tick();
        chk("t2_valid1", {63'b0, m_valid}, 64'd1);
        chk("t2_data1", {32'b0, m_data}, 64'h22);
        tick();
        chk("t2_valid2", {63'b0, m_valid}, 64'd1);
        chk("t2_data2", {32'b0, m_data}, 64'h33);
        chk("t2_last2", {63'b0, m_last}, 64'd0);
        tick();
        chk("t2_drained", {63'b0, m_valid}, 64'd0);
        // burst position is now 3

        // ---------------- 3: stalled consumer fills skid buffer --------------
        m_ready   = 1'b0;
        rd_pulses = 0;
        for (int i = 1; i <= 4; i++) fifo_mem.push_back(32'hA0 + i);
        fifo_update();
        for (int i = 0; i < 4; i++) tick();
        chk("t3_rd_pulses", 64'(rd_pulses), 64'd2);
        chk("t3_occ_full", {62'b0, occupancy}, 64'd2);
        chk("t3_held_data", {32'b0, m_data}, 64'hA1);
        chk("t3_held_last", {63'b0, m_last}, 64'd1);
        #1;
        chk("t3_no_fetch_full", {63'b0, fifo_read_en}, 64'd0);
        m_ready = 1'b1;
        tick();
        chk("t3_data_a2", {32'b0, m_data}, 64'hA2);
        chk("t3_occ_a2", {62'b0, occupancy}, 64'd1);
        chk("t3_last_a2", {63'b0, m_last}, 64'd0);
        tick();
        chk("t3_data_a3", {32'b0, m_data}, 64'hA3);
        tick();
        chk("t3_data_a4", {32'b0, m_data}, 64'hA4);
        chk("t3_valid_a4", {63'b0, m_valid}, 64'd1);
        tick();
        chk("t3_drained", {63'b0, m_valid}, 64'd0);
        chk("t3_occ_empty", {62'b0, occupancy}, 64'd0);

        // ---------------- 5: reset while the skid buffer is full -------------
        m_ready = 1'b0;
        fifo_mem.push_back(32'hB1);
        fifo_mem.push_back(32'hB2);
        fifo_mem.push_back(32'hB3);
        fifo_update();
        tick();
        tick();
        chk("t5_occ_full", {62'b0, occupancy}, 64'd2);
        read_reset = 1'b1;
        #1;
        chk("t5_rd_en_in_reset", {63'b0, fifo_read_en}, 64'd0);
        tick();
        chk("t5_valid", {63'b0, m_valid}, 64'd0);
        chk("t5_occ", {62'b0, occupancy}, 64'd0);
        read_reset = 1'b0;
        fifo_mem.delete();
        fifo_update();

        // ---------------- 4: nine beats, m_last on beats 4 and 8 -------------
        // A burst position left at 3 by a missing reset would flag beat 1.
        m_ready = 1'b1;
        for (int i = 1; i <= 9; i++) fifo_mem.push_back(32'hC0 + i);
        fifo_update();
        for (int i = 1; i <= 9; i++) begin
            tick();
            chk($sformatf("t4_data_beat%0d", i), {32'b0, m_data}, 64'(32'hC0 + i));
            chk($sformatf("t4_last_beat%0d", i), {63'b0, m_last}, 64'((i == 4) || (i == 8)));
        end
        tick();
        chk("t4_drained", {63'b0, m_valid}, 64'd0);
        // burst position is now 1

        // ---------------- drain_en = 0 stops fetching ------------------------
        drain_en = 1'b0;
        fifo_mem.push_back(32'hD1);
        fifo_update();
        #1;
        chk("drain_off_rd_en", {63'b0, fifo_read_en}, 64'd0);
        tick();
        chk("drain_off_valid", {63'b0, m_valid}, 64'd0);
        drain_en = 1'b1;
        tick();
        chk("drain_on_data", {32'b0, m_data}, 64'hD1);
        chk("drain_on_last", {63'b0, m_last}, 64'd0);
        tick();
        chk("drain_on_drained", {63'b0, m_valid}, 64'd0);

`ifdef AFIFO_RD_STATS_EN
        // ---------------- 6: statistics saturation ---------------------------
        read_reset = 1'b1;
        tick();
        read_reset = 1'b0;
        chk("t6_wc_reset", 64'(word_count), 64'd0);
        for (int i = 0; i < 20; i++) fifo_mem.push_back(32'hE0 + i);
        fifo_update();
        for (int i = 0; i < 22; i++) tick();
        chk("t6_wc_sat", 64'(word_count), 64'hF);
        chk("t6_sc_zero", 64'(stall_count), 64'd0);
        m_ready = 1'b0;
        fifo_mem.push_back(32'hF1);
        fifo_update();
        for (int i = 0; i < 4; i++) tick();
        chk("t6_sc_three", 64'(stall_count), 64'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
